// File: rtl/slot_ptr_ctrl.sv
// Pointer controller for the 4-slot, one-writer / two-reader packet buffer.
// Turns flags_gen greenflags into slot start/done handshakes and owns all three pointers.
//
// state  | meaning
// W_IDLE | writer has no slot; wr_start accepted when wr_greenflag is high
// W_FILL | writer owns slot wr_slot; wr_done commits, wr_abort discards
// R_IDLE | reader has no slot; rd_start_x accepted when rd_greenflag_x is high
// R_BUSY | reader owns slot rd_slot_x until rd_done_x releases it
module slot_ptr_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_greenflag,
    input  logic             rd_greenflag_1,
    input  logic             rd_greenflag_0,
    input  logic             wr_start,
    input  logic             wr_done,
    input  logic             wr_abort,
    input  logic             rd_start_1,
    input  logic             rd_start_0,
    input  logic             rd_done_1,
    input  logic             rd_done_0,
    output logic [2:0]       wr_ptr_tribit,
    output logic [2:0]       rd_ptr_tribit_1,
    output logic [2:0]       rd_ptr_tribit_0,
    output logic [1:0]       wr_slot,
    output logic [1:0]       rd_slot_1,
    output logic [1:0]       rd_slot_0,
    output logic             wr_ready,
    output logic             rd_valid_1,
    output logic             rd_valid_0,
    output logic             wr_busy,
    output logic             rd_busy_1,
    output logic             rd_busy_0,
    output logic [CNT_W-1:0] wr_reject_cnt
);

    typedef enum logic {W_IDLE, W_FILL} wr_state_t;
    typedef enum logic {R_IDLE, R_BUSY} rd_state_t;

    wr_state_t        wr_state_q, wr_state_d;
    logic [2:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rej_q, rej_d;

    rd_state_t        rd_state_q [2];
    rd_state_t        rd_state_d [2];
    logic [2:0]       rd_ptr_q [2];
    logic [2:0]       rd_ptr_d [2];

    logic [1:0]       rd_gf, rd_start, rd_done, rd_valid;

    // Index 1 is reader 1, index 0 is reader 0.
    assign rd_gf    = {rd_greenflag_1, rd_greenflag_0};
    assign rd_start = {rd_start_1, rd_start_0};
    assign rd_done  = {rd_done_1, rd_done_0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wr_ptr_q   <= '0;
            rej_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                rd_state_q[i] <= R_IDLE;
                rd_ptr_q[i]   <= '0;
            end
        end else begin
            wr_state_q <= wr_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rej_q      <= rej_d;
            for (int i = 0; i < 2; i++) begin
                rd_state_q[i] <= rd_state_d[i];
                rd_ptr_q[i]   <= rd_ptr_d[i];
            end
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q;
        rej_d      = rej_q;
        wr_ready   = wr_greenflag && (wr_state_q == W_IDLE);
        case (wr_state_q)
            W_IDLE: begin
                if (wr_start) begin
                    if (wr_ready) begin
                        wr_state_d = W_FILL;
                    end else if (rej_q != {CNT_W{1'b1}}) begin
                        rej_d = rej_q + CNT_W'(1);
                    end
                end
            end
            W_FILL: begin
                // Commit has priority over abort when both arrive together.
                if (wr_done) begin
                    wr_ptr_d   = wr_ptr_q + 3'd1;
                    wr_state_d = W_IDLE;
                end else if (wr_abort) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rd_state_d[i] = rd_state_q[i];
            rd_ptr_d[i]   = rd_ptr_q[i];
            rd_valid[i]   = rd_gf[i] && (rd_state_q[i] == R_IDLE);
            case (rd_state_q[i])
                R_IDLE: if (rd_start[i] && rd_valid[i]) rd_state_d[i] = R_BUSY;
                R_BUSY: begin
                    if (rd_done[i]) begin
                        rd_ptr_d[i]   = rd_ptr_q[i] + 3'd1;
                        rd_state_d[i] = R_IDLE;
                    end
                end
                default: rd_state_d[i] = R_IDLE;
            endcase
        end
    end

    assign wr_ptr_tribit   = wr_ptr_q;
    assign rd_ptr_tribit_1 = rd_ptr_q[1];
    assign rd_ptr_tribit_0 = rd_ptr_q[0];
    assign wr_slot         = wr_ptr_q[1:0];
    assign rd_slot_1       = rd_ptr_q[1][1:0];
    assign rd_slot_0       = rd_ptr_q[0][1:0];
    assign rd_valid_1      = rd_valid[1];
    assign rd_valid_0      = rd_valid[0];
    assign wr_busy         = (wr_state_q == W_FILL);
    assign rd_busy_1       = (rd_state_q[1] == R_BUSY);
    assign rd_busy_0       = (rd_state_q[0] == R_BUSY);
    assign wr_reject_cnt   = rej_q;

endmodule

// File: tb/tb_slot_ptr_ctrl.sv
// Bench for slot_ptr_ctrl: flags_gen is modelled from packet counts, and a
// count-based model of the handshakes is compared against the DUT every cycle.
module tb_slot_ptr_ctrl;

    localparam int CNT_W   = 3;
    localparam int REJ_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_start = 0, wr_done = 0, wr_abort = 0;
    logic rd_start_1 = 0, rd_start_0 = 0, rd_done_1 = 0, rd_done_0 = 0;
    logic wr_greenflag, rd_greenflag_1, rd_greenflag_0;

    logic [2:0] wr_ptr_tribit, rd_ptr_tribit_1, rd_ptr_tribit_0;
    logic [1:0] wr_slot, rd_slot_1, rd_slot_0;
    logic wr_ready, rd_valid_1, rd_valid_0, wr_busy, rd_busy_1, rd_busy_0;
    logic [CNT_W-1:0] wr_reject_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model: total packets committed / released, plus ownership flags.
    int m_wc = 0, m_rc1 = 0, m_rc0 = 0, m_rej = 0;
    bit m_fill = 0, m_busy1 = 0, m_busy0 = 0;

    assign wr_greenflag   = ((m_wc - m_rc1) < 4) && ((m_wc - m_rc0) < 4);
    assign rd_greenflag_1 = (m_rc1 < m_wc);
    assign rd_greenflag_0 = (m_rc0 < m_wc);

    always #5 clk = ~clk;

    slot_ptr_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .wr_greenflag(wr_greenflag), .rd_greenflag_1(rd_greenflag_1), .rd_greenflag_0(rd_greenflag_0),
        .wr_start(wr_start), .wr_done(wr_done), .wr_abort(wr_abort),
        .rd_start_1(rd_start_1), .rd_start_0(rd_start_0),
        .rd_done_1(rd_done_1), .rd_done_0(rd_done_0),
        .wr_ptr_tribit(wr_ptr_tribit), .rd_ptr_tribit_1(rd_ptr_tribit_1), .rd_ptr_tribit_0(rd_ptr_tribit_0),
        .wr_slot(wr_slot), .rd_slot_1(rd_slot_1), .rd_slot_0(rd_slot_0),
        .wr_ready(wr_ready), .rd_valid_1(rd_valid_1), .rd_valid_0(rd_valid_0),
        .wr_busy(wr_busy), .rd_busy_1(rd_busy_1), .rd_busy_0(rd_busy_0),
        .wr_reject_cnt(wr_reject_cnt)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wc <= 0; m_rc1 <= 0; m_rc0 <= 0; m_rej <= 0;
            m_fill <= 0; m_busy1 <= 0; m_busy0 <= 0;
        end else begin
            if (!m_fill) begin
                if (wr_start) begin
                    if (wr_greenflag) m_fill <= 1;
                    else if (m_rej < REJ_MAX) m_rej <= m_rej + 1;
                end
            end else if (wr_done) begin
                m_wc <= m_wc + 1; m_fill <= 0;
            end else if (wr_abort) begin
                m_fill <= 0;
            end
            if (!m_busy1) begin
                if (rd_start_1 && rd_greenflag_1) m_busy1 <= 1;
            end else if (rd_done_1) begin
                m_rc1 <= m_rc1 + 1; m_busy1 <= 0;
            end
            if (!m_busy0) begin
                if (rd_start_0 && rd_greenflag_0) m_busy0 <= 1;
            end else if (rd_done_0) begin
                m_rc0 <= m_rc0 + 1; m_busy0 <= 0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("wr_ptr",  int'(wr_ptr_tribit),   m_wc % 8);
            chk("rd_ptr1", int'(rd_ptr_tribit_1), m_rc1 % 8);
            chk("rd_ptr0", int'(rd_ptr_tribit_0), m_rc0 % 8);
            chk("wr_slot", int'(wr_slot),   m_wc % 4);
            chk("rd_slot1", int'(rd_slot_1), m_rc1 % 4);
            chk("rd_slot0", int'(rd_slot_0), m_rc0 % 4);
            chk("wr_ready", int'(wr_ready), int'(wr_greenflag && !m_fill));
            chk("rd_valid1", int'(rd_valid_1), int'(rd_greenflag_1 && !m_busy1));
            chk("rd_valid0", int'(rd_valid_0), int'(rd_greenflag_0 && !m_busy0));
            chk("wr_busy", int'(wr_busy), int'(m_fill));
            chk("rd_busy1", int'(rd_busy_1), int'(m_busy1));
            chk("rd_busy0", int'(rd_busy_0), int'(m_busy0));
            chk("reject_cnt", int'(wr_reject_cnt), m_rej);
        end
    end

    task automatic write_pkt();
        wr_start = 1; @(negedge clk); wr_start = 0;
        wr_done = 1;  @(negedge clk); wr_done = 0;
    endtask

    task automatic read_pkt(input bit r1, input bit r0);
        rd_start_1 = r1; rd_start_0 = r0; @(negedge clk);
        rd_start_1 = 0; rd_start_0 = 0;
        rd_done_1 = r1; rd_done_0 = r0; @(negedge clk);
        rd_done_1 = 0; rd_done_0 = 0;
    endtask

    task automatic reject_pulse();
        wr_start = 1; @(negedge clk); wr_start = 0; @(negedge clk);
    endtask

    task automatic ptrs(input string nm, input int w, input int r1, input int r0);
        chk({nm, ".wr"}, int'(wr_ptr_tribit), w);
        chk({nm, ".r1"}, int'(rd_ptr_tribit_1), r1);
        chk({nm, ".r0"}, int'(rd_ptr_tribit_0), r0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (5) @(negedge clk);
        ptrs("reset", 0, 0, 0);
        chk("reset.wr_ready", int'(wr_ready), 1);
        chk("reset.rd_valid1", int'(rd_valid_1), 0);
        chk("reset.rd_valid0", int'(rd_valid_0), 0);
        chk("reset.cnt", int'(wr_reject_cnt), 0);

        // single packet through both readers
        write_pkt();
        chk("single.wr_ptr", int'(wr_ptr_tribit), 1);
        chk("single.rd_valid1", int'(rd_valid_1), 1);
        chk("single.rd_valid0", int'(rd_valid_0), 1);
        read_pkt(1, 1);
        ptrs("single.read", 1, 1, 1);
        chk("single.empty1", int'(rd_valid_1), 0);
        chk("single.empty0", int'(rd_valid_0), 0);

        // stray handshakes while idle must be ignored
        wr_done = 1; wr_abort = 1; rd_done_1 = 1; rd_done_0 = 1; rd_start_0 = 1;
        @(negedge clk);
        wr_done = 0; wr_abort = 0; rd_done_1 = 0; rd_done_0 = 0; rd_start_0 = 0;
        ptrs("stray", 1, 1, 1);
        chk("stray.rd_busy0", int'(rd_busy_0), 0);

        // fill: 4 commits from 1 lands on 5, lag of 4 = full
        repeat (4) write_pkt();
        chk("full.wr_ptr", int'(wr_ptr_tribit), 5);
        chk("full.wr_ready", int'(wr_ready), 0);
        repeat (3) reject_pulse();
        chk("reject3", int'(wr_reject_cnt), 3);
        chk("reject3.wr_ptr", int'(wr_ptr_tribit), 5);
        repeat (6) reject_pulse();
        chk("reject_sat", int'(wr_reject_cnt), 7);

        // lagging reader 1 alone holds the writer off
        repeat (4) read_pkt(0, 1);
        ptrs("lag", 5, 1, 5);
        chk("lag.wr_ready", int'(wr_ready), 0);
        read_pkt(1, 0);
        chk("lag.release", int'(wr_ready), 1);
        repeat (3) read_pkt(1, 0);
        ptrs("caught_up", 5, 5, 5);

        // wrap: 10 packets from 5 -> 15 mod 8 = 7, one more -> 0
        repeat (10) begin write_pkt(); read_pkt(1, 1); end
        ptrs("wrap7", 7, 7, 7);
        write_pkt(); read_pkt(1, 1);
        ptrs("wrap0", 0, 0, 0);

        // abort leaves pointer; done+abort commits
        wr_start = 1; @(negedge clk); wr_start = 0;
        chk("abort.busy", int'(wr_busy), 1);
        wr_abort = 1; @(negedge clk); wr_abort = 0;
        chk("abort.wr_ptr", int'(wr_ptr_tribit), 0);
        chk("abort.idle", int'(wr_busy), 0);
        wr_start = 1; @(negedge clk); wr_start = 0;
        wr_done = 1; wr_abort = 1; @(negedge clk); wr_done = 0; wr_abort = 0;
        chk("done_wins", int'(wr_ptr_tribit), 1);
        read_pkt(1, 1);

        // simultaneous commit and releases
        write_pkt();
        wr_start = 1; rd_start_1 = 1; rd_start_0 = 1; @(negedge clk);
        wr_start = 0; rd_start_1 = 0; rd_start_0 = 0;
        wr_done = 1; rd_done_1 = 1; rd_done_0 = 1; @(negedge clk);
        wr_done = 0; rd_done_1 = 0; rd_done_0 = 0;
        ptrs("simul", 3, 2, 2);
        read_pkt(1, 1);

        // async reset mid-operation
        write_pkt();
        wr_start = 1; rd_start_1 = 1; @(negedge clk);
        wr_start = 0; rd_start_1 = 0;
        chk("pre_rst.wr_busy", int'(wr_busy), 1);
        chk("pre_rst.rd_busy1", int'(rd_busy_1), 1);
        #2 rst = 1;
        #1;
        ptrs("async_rst", 0, 0, 0);
        chk("async_rst.wr_busy", int'(wr_busy), 0);
        chk("async_rst.rd_busy1", int'(rd_busy_1), 0);
        chk("async_rst.wr_ready", int'(wr_ready), 1);
        chk("async_rst.rd_valid1", int'(rd_valid_1), 0);
        chk("async_rst.cnt", int'(wr_reject_cnt), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        write_pkt(); read_pkt(1, 1);
        ptrs("resume", 1, 1, 1);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
